// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Turns the ID/EX memory-control fields
// into one aligned 64-bit bus transaction, holds the pipeline with `stall`
// while the access is in flight, and returns extended load data on `done`.
module mem_lsu #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_ena,
  input  logic              ex_mem_wen,
  input  logic [3:0]        ex_mem_mask,
  input  logic [1:0]        ex_sel_memdata,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_rf_rdata2,
  output logic              stall,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_wen,
  output logic [DATA_W-1:0] req_wdata,
  output logic [7:0]        req_wstrb,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic              done,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_off;
  logic [1:0]  r_size;
  logic        r_sign;

  logic        w_start;
  logic        w_legal;
  logic        w_accept;
  logic        w_reject;
  logic        w_handshake;
  logic        w_complete;
  logic [1:0]  w_size;
  logic [2:0]  w_off;
  logic [7:0]  w_strb_base;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata;
  logic [63:0] w_shifted;
  logic [63:0] w_load;
  logic        w_unused;

  // The reserved select bit carries no meaning in this unit.
  assign w_unused = ex_sel_memdata[1];

  // True only for exactly one bit set in the size mask.
  function automatic logic f_onehot4(input logic [3:0] m);
    return (m == 4'b0001) | (m == 4'b0010) | (m == 4'b0100) | (m == 4'b1000);
  endfunction

  // log2 of the access size in bytes; illegal masks are caught by f_onehot4.
  function automatic logic [1:0] f_size_code(input logic [3:0] m);
    logic [1:0] c;
    case (m)
      4'b0001: c = 2'd0;
      4'b0010: c = 2'd1;
      4'b0100: c = 2'd2;
      4'b1000: c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // Natural alignment: the byte offset must be a multiple of the size.
  function automatic logic f_aligned(input logic [1:0] sz, input logic [2:0] off);
    logic a;
    case (sz)
      2'd0:    a = 1'b1;
      2'd1:    a = (off[0] == 1'b0);
      2'd2:    a = (off[1:0] == 2'b00);
      default: a = (off == 3'b000);
    endcase
    return a;
  endfunction

  // Decode the incoming EX fields into legality and lane-shifted payload.
  always_comb begin
    w_start = ex_valid & ex_mem_ena;
    w_off   = ex_addr[2:0];
    w_size  = f_size_code(ex_mem_mask);
    w_legal = f_onehot4(ex_mem_mask) & f_aligned(w_size, w_off);
    case (w_size)
      2'd0:    w_strb_base = 8'h01;
      2'd1:    w_strb_base = 8'h03;
      2'd2:    w_strb_base = 8'h0F;
      default: w_strb_base = 8'hFF;
    endcase
    w_wstrb = w_strb_base << w_off;
    w_wdata = ex_rf_rdata2 << {w_off, 3'b000};
  end

  // Next-state logic plus the combinational stall and event strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_handshake = 1'b0;
    w_complete  = 1'b0;
    stall       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_legal) begin
            w_accept    = 1'b1;
            stall       = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_reject    = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (req_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        // Stall drops in the response cycle so EX advances exactly once.
        if (resp_valid) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          stall       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Align the returned beat to byte 0 and extend it from the access size.
  always_comb begin
    w_shifted = resp_rdata >> {r_off, 3'b000};
    case (r_size)
      2'd0:    w_load = {{56{r_sign & w_shifted[7]}},  w_shifted[7:0]};
      2'd1:    w_load = {{48{r_sign & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    w_load = {{32{r_sign & w_shifted[31]}}, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched access context and registered bus/writeback outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_addr  <= {ADDR_W{1'b0}};
      req_wen   <= 1'b0;
      req_wdata <= {DATA_W{1'b0}};
      req_wstrb <= 8'h00;
      done      <= 1'b0;
      err       <= 1'b0;
      wb_rdata  <= {DATA_W{1'b0}};
      r_off     <= 3'd0;
      r_size    <= 2'd0;
      r_sign    <= 1'b0;
    end else begin
      done <= w_complete;
      err  <= w_reject;
      if (w_accept) begin
        req_valid <= 1'b1;
        req_addr  <= {ex_addr[ADDR_W-1:3], 3'b000};
        req_wen   <= ex_mem_wen;
        req_wdata <= w_wdata;
        req_wstrb <= w_wstrb;
        r_off     <= w_off;
        r_size    <= w_size;
        r_sign    <= ex_sel_memdata[0];
      end else if (w_handshake) begin
        req_valid <= 1'b0;
      end
      if (w_complete) begin
        wb_rdata <= req_wen ? {DATA_W{1'b0}} : w_load;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vector table, hand-written reset/backpressure
// sequences and randomized accesses checked against an arithmetic model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_ena, ex_mem_wen;
  logic [3:0]  ex_mem_mask;
  logic [1:0]  ex_sel_memdata;
  logic [63:0] ex_addr, ex_rf_rdata2;
  logic        stall, req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        done, err;
  logic [63:0] wb_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  mask;
    logic [1:0]  sel;
    logic        wen;
    logic [63:0] rdata2;
    logic [63:0] rdata;
    logic        exp_err;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_wb;
  } vec_t;

  vec_t tbl[13];

  mem_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_ena(ex_mem_ena), .ex_mem_wen(ex_mem_wen),
    .ex_mem_mask(ex_mem_mask), .ex_sel_memdata(ex_sel_memdata),
    .ex_addr(ex_addr), .ex_rf_rdata2(ex_rf_rdata2),
    .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .done(done), .wb_rdata(wb_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] addr, input logic [3:0] mask,
                              input logic [1:0] sel, input logic wen,
                              input logic [63:0] rdata2, input logic [63:0] rdata,
                              input logic e_err, input logic [63:0] e_addr,
                              input logic [7:0] e_strb, input logic [63:0] e_wdata,
                              input logic [63:0] e_wb);
    vec_t v;
    v.addr = addr; v.mask = mask; v.sel = sel; v.wen = wen;
    v.rdata2 = rdata2; v.rdata = rdata; v.exp_err = e_err;
    v.exp_addr = e_addr; v.exp_strb = e_strb; v.exp_wdata = e_wdata; v.exp_wb = e_wb;
    return v;
  endfunction

  // Reference model: plain byte arithmetic on the access description.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    longint unsigned size, off, t, lim;
    r = v;
    size = (v.mask == 4'b0001) ? 1 : (v.mask == 4'b0010) ? 2 :
           (v.mask == 4'b0100) ? 4 : (v.mask == 4'b1000) ? 8 : 0;
    off = v.addr % 8;
    if (size == 0) r.exp_err = 1'b1;
    else           r.exp_err = ((v.addr % size) != 0);
    r.exp_addr  = v.addr - off;
    r.exp_strb  = 8'(((64'd1 << size) - 64'd1) << off);
    r.exp_wdata = v.rdata2 << (8 * off);
    if (v.wen) begin
      r.exp_wb = 64'd0;
    end else begin
      t = v.rdata >> (8 * off);
      if (size < 8) begin
        lim = 64'd1 << (8 * size);
        t = t % lim;
        if (v.sel[0] && t >= lim / 2) t = t - lim;
      end
      r.exp_wb = t;
    end
    return r;
  endfunction

  task automatic drive_idle();
    ex_valid = 1'b0; ex_mem_ena = 1'b0; ex_mem_wen = 1'b0;
    ex_mem_mask = 4'b0000; ex_sel_memdata = 2'b00;
    ex_addr = 64'd0; ex_rf_rdata2 = 64'd0;
  endtask

  // Live-looking junk on the EX fields; must be ignored outside IDLE.
  task automatic drive_garbage();
    ex_valid = 1'b1; ex_mem_ena = 1'b1; ex_mem_wen = 1'($urandom);
    ex_mem_mask = 4'($urandom); ex_sel_memdata = 2'($urandom);
    ex_addr = {$urandom, $urandom}; ex_rf_rdata2 = {$urandom, $urandom};
  endtask

  task automatic drive_vec(input vec_t v);
    ex_valid = 1'b1; ex_mem_ena = 1'b1; ex_mem_wen = v.wen;
    ex_mem_mask = v.mask; ex_sel_memdata = v.sel;
    ex_addr = v.addr; ex_rf_rdata2 = v.rdata2;
  endtask

  // One access starting at the current negedge; returns at the done cycle.
  task automatic run_access(input vec_t v, input int rd, input int wd, input bit idle_after);
    drive_vec(v);
    req_ready = 1'b0; resp_valid = 1'b0;
    #1 chk("stall_start", 64'(stall), 64'(!v.exp_err));
    @(negedge clk);
    if (v.exp_err) begin
      drive_idle();
      #1;
      chk("err_pulse", 64'(err), 64'd1);
      chk("err_no_req", 64'(req_valid), 64'd0);
      chk("err_no_stall", 64'(stall), 64'd0);
      if (idle_after) begin
        @(negedge clk);
        #1 chk("err_one_cycle", 64'(err), 64'd0);
      end
      return;
    end
    for (int i = 0; i <= rd; i++) begin
      drive_garbage();
      req_ready  = (i == rd);
      resp_valid = (i != rd) ? 1'($urandom) : 1'b0;
      resp_rdata = {$urandom, $urandom};
      #1;
      chk("req_valid", 64'(req_valid), 64'd1);
      chk("req_addr", req_addr, v.exp_addr);
      chk("req_wen", 64'(req_wen), 64'(v.wen));
      chk("req_wdata", req_wdata, v.exp_wdata);
      chk("req_wstrb", 64'(req_wstrb), 64'(v.exp_strb));
      chk("req_stall", 64'(stall), 64'd1);
      chk("req_no_done", 64'(done), 64'd0);
      chk("req_no_err", 64'(err), 64'd0);
      @(negedge clk);
    end
    for (int j = 0; j <= wd; j++) begin
      if (j == wd) drive_idle();
      else         drive_garbage();
      req_ready  = 1'($urandom);
      resp_valid = (j == wd);
      resp_rdata = (j == wd) ? v.rdata : {$urandom, $urandom};
      #1;
      chk("wait_no_req", 64'(req_valid), 64'd0);
      chk("wait_stall", 64'(stall), 64'(j != wd));
      chk("wait_no_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    resp_valid = 1'b0; req_ready = 1'b0;
    #1;
    chk("done", 64'(done), 64'd1);
    chk("wb_rdata", wb_rdata, v.exp_wb);
    chk("done_no_err", 64'(err), 64'd0);
    if (idle_after) begin
      @(negedge clk);
      #1 chk("done_one_pulse", 64'(done), 64'd0);
    end
  endtask

  initial begin
    vec_t v;
    logic [2:0] lowmask;

    tbl[0]  = mk(64'h8000_0003, 4'b0001, 2'b01, 1'b0, 64'h0, 64'h0000_0000_8000_0000,
                 1'b0, 64'h8000_0000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
    tbl[1]  = mk(64'h8000_0006, 4'b0010, 2'b00, 1'b1, 64'h1234, 64'hDEAD_BEEF_DEAD_BEEF,
                 1'b0, 64'h8000_0000, 8'hC0, 64'h1234_0000_0000_0000, 64'h0);
    tbl[2]  = mk(64'h8000_0002, 4'b0100, 2'b00, 1'b0, 64'h0, 64'h0,
                 1'b1, 64'h0, 8'h00, 64'h0, 64'h0);
    tbl[3]  = mk(64'h8000_0004, 4'b0100, 2'b00, 1'b0, 64'h0, 64'hF000_0000_0000_0000,
                 1'b0, 64'h8000_0000, 8'hF0, 64'h0, 64'h0000_0000_F000_0000);
    tbl[4]  = mk(64'h0, 4'b0011, 2'b00, 1'b0, 64'h0, 64'h0,
                 1'b1, 64'h0, 8'h00, 64'h0, 64'h0);
    tbl[5]  = mk(64'h8, 4'b0000, 2'b00, 1'b0, 64'h0, 64'h0,
                 1'b1, 64'h0, 8'h00, 64'h0, 64'h0);
    tbl[6]  = mk(64'h10, 4'b1000, 2'b01, 1'b0, 64'h0, 64'h8123_4567_89AB_CDEF,
                 1'b0, 64'h10, 8'hFF, 64'h0, 64'h8123_4567_89AB_CDEF);
    tbl[7]  = mk(64'h22, 4'b0010, 2'b01, 1'b0, 64'h0, 64'h0000_0000_8001_0000,
                 1'b0, 64'h20, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
    tbl[8]  = mk(64'h104, 4'b0100, 2'b00, 1'b1, 64'hFFFF_FFFF_AABB_CCDD, 64'h5555,
                 1'b0, 64'h100, 8'hF0, 64'hAABB_CCDD_0000_0000, 64'h0);
    tbl[9]  = mk(64'h7, 4'b0001, 2'b00, 1'b0, 64'h0, 64'hFE00_0000_0000_0000,
                 1'b0, 64'h0, 8'h80, 64'h0, 64'hFE);
    tbl[10] = mk(64'h1, 4'b0001, 2'b10, 1'b0, 64'h0, 64'h0000_0000_0000_8000,
                 1'b0, 64'h0, 8'h02, 64'h0, 64'h80);
    tbl[11] = mk(64'hC, 4'b1000, 2'b00, 1'b0, 64'h0, 64'h0,
                 1'b1, 64'h0, 8'h00, 64'h0, 64'h0);
    tbl[12] = mk(64'h3, 4'b0010, 2'b01, 1'b0, 64'h0, 64'h0,
                 1'b1, 64'h0, 8'h00, 64'h0, 64'h0);

    rst = 1'b1; drive_idle(); req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 64'd0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_wen", 64'(req_wen), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_req_addr", req_addr, 64'd0);
    chk("rst_req_wdata", req_wdata, 64'd0);
    chk("rst_req_wstrb", 64'(req_wstrb), 64'd0);
    chk("rst_wb_rdata", wb_rdata, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table, immediate handshakes.
    for (int i = 0; i < 13; i++) run_access(tbl[i], 0, 0, 1'b1);

    // Backpressure: ready held off 4 cycles, response 5 cycles late.
    run_access(tbl[0], 4, 5, 1'b1);
    run_access(tbl[1], 4, 5, 1'b1);

    // Back-to-back: next start in the done cycle of the previous access.
    run_access(tbl[3], 0, 0, 1'b0);
    run_access(tbl[7], 0, 0, 1'b0);
    run_access(tbl[2], 0, 0, 1'b0);
    run_access(tbl[6], 0, 0, 1'b1);

    // Response while idle must not produce done.
    resp_valid = 1'b1; resp_rdata = 64'h1;
    @(negedge clk);
    resp_valid = 1'b0;
    #1 chk("idle_resp_no_done", 64'(done), 64'd0);
    @(negedge clk);

    // Randomized accesses against the model.
    for (int n = 0; n < 200; n++) begin
      v.mask = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      v.addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) begin
        lowmask = (v.mask == 4'b0010) ? 3'b001 : (v.mask == 4'b0100) ? 3'b011 :
                  (v.mask == 4'b1000) ? 3'b111 : 3'b000;
        v.addr[2:0] = v.addr[2:0] & ~lowmask;
      end
      v.sel = 2'($urandom); v.wen = 1'($urandom);
      v.rdata2 = {$urandom, $urandom}; v.rdata = {$urandom, $urandom};
      run_access(model(v), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    drive_idle();
    @(negedge clk);

    // Reset while a request is pending.
    drive_vec(tbl[6]); req_ready = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    drive_idle();
    #1 chk("rreq_pre_valid", 64'(req_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rreq_valid", 64'(req_valid), 64'd0);
    chk("rreq_stall", 64'(stall), 64'd0);
    chk("rreq_addr", req_addr, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset while waiting for the response, then a stray response.
    drive_vec(tbl[0]);
    @(negedge clk);
    drive_idle(); req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #1 chk("rwait_pre_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    chk("rwait_stall", 64'(stall), 64'd0);
    chk("rwait_valid", 64'(req_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0; resp_valid = 1'b1; resp_rdata = 64'h0000_0000_8000_0000;
    @(negedge clk);
    resp_valid = 1'b0;
    #1 chk("rwait_no_done", 64'(done), 64'd0);
    @(negedge clk);
    #1 chk("rwait_no_done2", 64'(done), 64'd0);
    run_access(tbl[3], 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the NPC pipeline. It consumes the memory-control fields held in the ID/EX pipeline register and issues one aligned 64-bit bus transaction per memory instruction. It returns sign- or zero-extended load data for writeback. While a transaction is outstanding it drives `stall`, which the pipeline uses to hold the EX register's `ena` low.

## Interface
Parameters
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: bus data width. Fixed at 64; other values are unsupported.

Ports
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ex_valid`  in  1: EX stage holds a live instruction.
- `ex_mem_ena`  in  1: the instruction accesses memory.
- `ex_mem_wen`  in  1: 1 = store, 0 = load.
- `ex_mem_mask`  in  4: access size, one-hot {dword, word, half, byte}.
- `ex_sel_memdata`  in  2: bit0 = sign-extend the load; bit1 is reserved and ignored.
- `ex_addr`  in  64: effective address (ALU result).
- `ex_rf_rdata2`  in  64: store data, LSB-justified.
- `stall`  out  1: hold the EX pipeline register.
- `req_valid`  out  1: bus request valid.
- `req_ready`  in  1: bus accepts the request.
- `req_addr`  out  64: 8-byte-aligned address.
- `req_wen`  out  1: write request.
- `req_wdata`  out  64: lane-shifted store data.
- `req_wstrb`  out  8: byte strobes.
- `resp_valid`  in  1: read data or write acknowledge is present.
- `resp_rdata`  in  64: read data.
- `done`  out  1: one-cycle pulse when the access completes.
- `wb_rdata`  out  64: extended load data, meaningful when `done` is high for a load.
- `err`  out  1: one-cycle pulse on a misaligned access or an illegal mask.

## Operation
- **Start condition:** `start = ex_valid & ex_mem_ena`.
- **Size:** 1, 2, 4 or 8 bytes, taken from the one-hot mask. `off = ex_addr[2:0]`.
- **Legality:**
  - The mask must be exactly one-hot.
  - `off` must be a multiple of the size.
  - An illegal start pulses `err` for one cycle, issues no request, does not stall, and the FSM stays in IDLE.
- **FSM states:** IDLE, REQ, WAIT.
  - **IDLE:** on a legal start, latch addr, wen, size, sign, wdata and off, then go to REQ.
  - **REQ:** `req_valid` is 1 with stable payload. When `req_ready` is seen, go to WAIT.
  - **WAIT:** when `resp_valid` is seen, pulse `done`, drive `wb_rdata`, and go to IDLE.
- **Request payload:**
  - `req_addr = {addr[63:3], 3'b0}`.
  - `req_wstrb = ((1<<size)-1) << off`.
  - `req_wdata = rdata2 << (8*off)`.
  - `req_wen = wen`.
- **Load data:** `t = resp_rdata >> (8*off)`. Truncate `t` to the access size, then sign- or zero-extend it to 64 bits according to the latched sign bit. A dword load returns `t` unchanged.
- **Stores:** complete on the write acknowledge (`resp_valid`). `wb_rdata` is 0 for stores.
- **Stall:** combinational, `stall = (IDLE & legal start) | REQ | (WAIT & ~resp_valid)`. This makes `stall` low in the completion cycle, so the EX register advances exactly once per access.
- **Ignored inputs:** `ex_*` inputs are ignored in REQ and WAIT. All payload comes from latched copies.

## Timing
- **Reset values:** state = IDLE; `req_valid`, `req_wen`, `done` and `err` are 0; `req_addr`, `req_wdata`, `req_wstrb` and `wb_rdata` are 0.
- **Register placement:** `req_*`, `done`, `wb_rdata` and `err` are registered outputs. Only `stall` is combinational.
- **Latency:**
  - The start cycle is T.
  - `req_valid` rises at T+1.
  - A handshake at cycle R moves the FSM to WAIT at R+1.
  - With `resp_valid` at cycle W, where W ≥ R+1, `done` is high at W+1.
  - Minimum start-to-`done` latency is 3 cycles.
- **Stall release:** `stall` falls in cycle W, the response cycle. The completion and `done` take effect at the following edge.
- **resp_valid outside WAIT:** ignored. It must not produce `done`.
- **Back-to-back accesses:** a new legal start in IDLE at W+1 is accepted. `done` for the previous access and acceptance of the next may coincide.
- **Asynchronous reset mid-transaction:** immediately forces IDLE and drops `req_valid` and `stall`. The bus slave must tolerate an abandoned request.

## Test plan
- Byte load, signed: addr=0x80000003, mask=0001, sel=01, resp_rdata=0x00000000_80000000 → `wb_rdata`=0xFFFFFFFF_FFFFFF80 and `done` pulse 3 cycles after start when `req_ready` and `resp_valid` respond immediately.
- Half store: addr=0x80000006, mask=0010, rdata2=0x1234 → `req_addr`=0x80000000, `req_wstrb`=0xC0, `req_wdata`=0x1234_0000_0000_0000, `req_wen`=1.
- Backpressure: `req_ready` low for 4 cycles, `resp_valid` delayed 5 cycles → payload stable throughout, `stall` high until the `resp_valid` cycle, exactly one `done`.
- Misaligned word load at addr=0x80000002 → `err` pulse, no `req_valid`, `stall` low.
- Unsigned word load: addr=0x80000004, mask=0100, sel=00, resp=0xF000_0000_0000_0000 → `wb_rdata`=0x00000000_F0000000.
- Assert `rst` while in WAIT → `stall`=0 and `req_valid`=0 immediately; a later spurious `resp_valid` gives no `done`.
